// File: rtl/time_keeper.sv
// ---------------------------------------------------------------------------
// time_keeper
//   24-hour wall clock driven by a CLK_HZ-cycle prescaler. While set_mod is
//   high the time is frozen. On the cycle after set_mod falls, the time is
//   loaded from the setting stage; any out-of-range field loads as 0.
//
// Handshake: none. Inputs are sampled on every rising clk edge. Outputs are
//   registered. Each pulse output is high for exactly one cycle.
//
// Ports
//   clk          system clock, all state on rising edge
//   reset        asynchronous, active-low reset
//   set_mod      level, high = time-setting mode
//   set_hours    edited hours   (8 bit, >23 loads as 0)
//   set_minutes  edited minutes (8 bit, >59 loads as 0)
//   set_seconds  edited seconds (8 bit, >59 loads as 0)
//   seconds      running seconds 0..59
//   minutes      running minutes 0..59
//   hours        running hours   0..23
//   tick_1hz     one-cycle pulse per elapsed second
//   hour_chime   one-cycle pulse when minutes:seconds roll to 00:00
//   day_wrap     one-cycle pulse on 23:59:59 -> 00:00:00
//   dbg_state    current mode state (0 = RUN, 1 = SET), i.e. registered set_mod
// ---------------------------------------------------------------------------
module time_keeper #(
   parameter int unsigned CLK_HZ = 100000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       set_mod,
   input  logic [7:0] set_hours,
   input  logic [7:0] set_minutes,
   input  logic [7:0] set_seconds,
   output logic [5:0] seconds,
   output logic [5:0] minutes,
   output logic [5:0] hours,
   output logic       tick_1hz,
   output logic       hour_chime,
   output logic       day_wrap,
   output logic       dbg_state
);

   localparam int unsigned PW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(CLK_HZ - 1);

   typedef enum logic {
      ST_RUN = 1'b0,
      ST_SET = 1'b1
   } state_e;

   state_e        state_q, state_d;
   logic [PW-1:0] pre_q, pre_d;
   logic [5:0]    sec_q, sec_d;
   logic [5:0]    min_q, min_d;
   logic [5:0]    hr_q, hr_d;
   logic          tick_q, tick_d;
   logic          chime_q, chime_d;
   logic          wrap_q, wrap_d;

   // State register: this is the once-registered copy of set_mod.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = set_mod ? ST_SET : ST_RUN;
   end

   // Datapath next-state. Priority: set_mod high (hold) > load on SET exit >
   // normal counting. The hold branch also covers the 0->1 edge, so a tick
   // that lands on that cycle is discarded.
   always_comb begin
      pre_d   = pre_q;
      sec_d   = sec_q;
      min_d   = min_q;
      hr_d    = hr_q;
      tick_d  = 1'b0;
      chime_d = 1'b0;
      wrap_d  = 1'b0;

      if (set_mod) begin
         pre_d = '0;
      end else if (state_q == ST_SET) begin
         pre_d = '0;
         sec_d = (set_seconds > 8'd59) ? 6'd0 : set_seconds[5:0];
         min_d = (set_minutes > 8'd59) ? 6'd0 : set_minutes[5:0];
         hr_d  = (set_hours   > 8'd23) ? 6'd0 : set_hours[5:0];
      end else if (pre_q == PRE_MAX) begin
         pre_d  = '0;
         tick_d = 1'b1;
         if (sec_q == 6'd59) begin
            sec_d = 6'd0;
            if (min_q == 6'd59) begin
               min_d   = 6'd0;
               chime_d = 1'b1;
               if (hr_q == 6'd23) begin
                  hr_d   = 6'd0;
                  wrap_d = 1'b1;
               end else begin
                  hr_d = hr_q + 6'd1;
               end
            end else begin
               min_d = min_q + 6'd1;
            end
         end else begin
            sec_d = sec_q + 6'd1;
         end
      end else begin
         pre_d = pre_q + PW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pre_q   <= '0;
         sec_q   <= '0;
         min_q   <= '0;
         hr_q    <= '0;
         tick_q  <= 1'b0;
         chime_q <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         pre_q   <= pre_d;
         sec_q   <= sec_d;
         min_q   <= min_d;
         hr_q    <= hr_d;
         tick_q  <= tick_d;
         chime_q <= chime_d;
         wrap_q  <= wrap_d;
      end
   end

   assign seconds    = sec_q;
   assign minutes    = min_q;
   assign hours      = hr_q;
   assign tick_1hz   = tick_q;
   assign hour_chime = chime_q;
   assign day_wrap   = wrap_q;
   assign dbg_state  = state_q;

endmodule

// File: doc/time_keeper.md
TIME_KEEPER -- requirements
Module: time_keeper

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100000000, input clock cycles per second (minimum 2).
REQ-002 SHALL have port clk  input  1  system clock (100 MHz), all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port set_mod  input  1  level, high = time-setting mode active.
REQ-005 SHALL have port set_hours  input  8  edited hours from the setting stage.
REQ-006 SHALL have port set_minutes  input  8  edited minutes from the setting stage.
REQ-007 SHALL have port set_seconds  input  8  edited seconds from the setting stage.
REQ-008 SHALL have port seconds  output  6  running seconds, 0..59, registered.
REQ-009 SHALL have port minutes  output  6  running minutes, 0..59, registered.
REQ-010 SHALL have port hours  output  6  running hours, 0..23, registered.
REQ-011 SHALL have port tick_1hz  output  1  one-cycle pulse per elapsed second.
REQ-012 SHALL have port hour_chime  output  1  one-cycle pulse when minutes and seconds both wrap to 0.
REQ-013 SHALL have port day_wrap  output  1  one-cycle pulse on 23:59:59 -> 00:00:00.

Function
REQ-014 SHALL count clk cycles in a prescaler of width clog2(CLK_HZ), 0..CLK_HZ-1, asserting an internal tick when the count equals CLK_HZ-1 and wrapping to 0.
REQ-015 SHALL operate in two states, RUN and SET; SET entered when set_mod is 1, RUN when set_mod is 0.
REQ-016 SHALL, in RUN, on each internal tick, increment seconds; 59 -> 0 with carry to minutes; minutes 59 -> 0 with carry to hours; hours 23 -> 0.
REQ-017 SHALL update seconds/minutes/hours and pulse tick_1hz in the same cycle, i.e. one clk after the prescaler reaches CLK_HZ-1.
REQ-018 SHALL pulse hour_chime in the cycle minutes and seconds both become 0 by carry, and day_wrap additionally when hours also become 0 by carry.
REQ-019 SHALL, in SET, hold seconds/minutes/hours, hold the prescaler at 0, and keep tick_1hz, hour_chime and day_wrap low.
REQ-020 SHALL register set_mod once and detect its 1 -> 0 transition; in the cycle after the transition, load seconds/minutes/hours from set_seconds/set_minutes/set_hours (low 6 bits).
REQ-021 SHALL replace any loaded field whose 8-bit input is out of range (seconds/minutes > 59, hours > 23) with 0, independently per field.
REQ-022 SHALL restart the prescaler at 0 on the load cycle, so the first tick after load occurs exactly CLK_HZ cycles later; no pulse outputs on the load cycle.
REQ-023 SHALL not count in the set_mod 0 -> 1 transition cycle; the prescaler is cleared in that cycle and any coincident tick is discarded.
REQ-024 SHALL treat a set_mod pulse of one cycle as a full SET entry and exit (hold, then load).

Reset
REQ-025 SHALL, while reset is 0, force seconds, minutes, hours, prescaler, registered set_mod and all pulse outputs to 0, independent of clk.
REQ-026 SHALL resume counting from 00:00:00 with the prescaler at 0 on the first rising clk edge after reset deasserts; a reset mid-load or mid-count leaves no partial update.
REQ-027 SHALL not produce a load on the first edge after reset when set_mod is 0.

Verification (CLK_HZ=4)
REQ-028 SHALL cover: reset release, set_mod=0 for 12 clk -> tick_1hz every 4th cycle, seconds 0->3.
REQ-029 SHALL cover: load 23:59:58, 8 clk -> 23:59:59 after 4 clk, then 00:00:00 with tick_1hz, hour_chime and day_wrap high for one cycle.
REQ-030 SHALL cover: load 10:59:59, 4 clk -> 11:00:00, hour_chime=1, day_wrap=0.
REQ-031 SHALL cover: set_mod high 20 clk -> outputs frozen, no pulses; on release with set 12:34:56 -> outputs 12:34:56 one cycle after the falling edge.
REQ-032 SHALL cover: load set_hours=30, set_minutes=60, set_seconds=7 -> 00:00:07.
REQ-033 SHALL cover: reset asserted at 05:06:07 mid-prescaler, asynchronous to clk -> outputs 00:00:00 immediately, no pulse on release.
